permute_fsm: RTL and testbench

Second-stage controller of the SHAKE core. It sits directly downstream of the input load stage. It consumes each rate block that stage publishes through the shared `input_buffer_ready` handshake flag and XOR-absorbs it into the Keccak state. It then sequences the round datapath through `NUM_ROUNDS` rounds and, after the last input block, squeezes rate blocks into the output buffer until the requested block count is produced.

---
 rtl/permute_fsm.sv | 171 +++++++++++++++++
 tb/tb_permute_fsm.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/permute_fsm.sv
// permute_fsm: SHAKE core second stage. Absorbs rate blocks published by the
// load stage, sequences the Keccak-f round datapath and squeezes output blocks.
//
// Build option: define PERMUTE_UNROLL2_EN when the round datapath applies two
// rounds per cycle (round_index then carries the even index of each pair and
// NUM_ROUNDS must be even).
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_RESET     | zero the Keccak state, clear counters
// ST_WAIT_BLOCK| idle, waiting for a rate block in the input buffer
// ST_PERMUTE   | applying the round function, round_cnt tracks progress
// ST_WAIT_OUTPUT| squeezing, waiting for the output buffer to drain
// ST_FLUSH     | message finished, zero the Keccak state
module permute_fsm #(
    parameter int NUM_ROUNDS  = 24,
    parameter int ROUND_W     = 5,
    parameter int BLOCK_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_buffer_ready,
    input  logic                   last_block_in_buffer,
    input  logic                   output_buffer_ready,
    input  logic [BLOCK_CNT_W-1:0] output_blocks,
    output logic                   state_reset,
    output logic                   absorb_enable,
    output logic                   input_buffer_ready_clr,
    output logic                   round_en,
    output logic [ROUND_W-1:0]     round_index,
    output logic                   output_load_enable,
    output logic                   output_buffer_ready_wr,
    output logic                   last_output_block,
    output logic                   busy
);

`ifdef PERMUTE_UNROLL2_EN
    localparam int ROUND_STEP = 2;
`else
    localparam int ROUND_STEP = 1;
`endif

    localparam logic [ROUND_W-1:0] ROUND_STEP_C = ROUND_W'(ROUND_STEP);
    localparam logic [ROUND_W-1:0] ROUND_LAST   = ROUND_W'(NUM_ROUNDS - ROUND_STEP);

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_WAIT_BLOCK  = 3'd1,
        ST_PERMUTE     = 3'd2,
        ST_WAIT_OUTPUT = 3'd3,
        ST_FLUSH       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ROUND_W-1:0]     round_cnt_q, round_cnt_d;
    logic [BLOCK_CNT_W-1:0] squeeze_cnt_q, squeeze_cnt_d;
    logic                   last_q, last_d;

    // One extra bit keeps squeeze_cnt + 1 from wrapping at all-ones.
    logic [BLOCK_CNT_W:0] eff_blocks;
    logic [BLOCK_CNT_W:0] squeeze_next;
    logic                 done_now;

    // Block count of zero still emits one block.
    always_comb begin
        eff_blocks   = (output_blocks == '0) ? (BLOCK_CNT_W+1)'(1) : {1'b0, output_blocks};
        squeeze_next = {1'b0, squeeze_cnt_q} + (BLOCK_CNT_W+1)'(1);
        done_now     = (squeeze_next >= eff_blocks);
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RESET;
            round_cnt_q   <= '0;
            squeeze_cnt_q <= '0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_cnt_q   <= round_cnt_d;
            squeeze_cnt_q <= squeeze_cnt_d;
            last_q        <= last_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d                = state_q;
        round_cnt_d            = round_cnt_q;
        squeeze_cnt_d          = squeeze_cnt_q;
        last_d                 = last_q;
        state_reset            = 1'b0;
        absorb_enable          = 1'b0;
        input_buffer_ready_clr = 1'b0;
        round_en               = 1'b0;
        round_index            = '0;
        output_load_enable     = 1'b0;
        output_buffer_ready_wr = 1'b0;
        last_output_block      = 1'b0;
        busy                   = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_reset   = 1'b1;
                busy          = 1'b1;
                round_cnt_d   = '0;
                squeeze_cnt_d = '0;
                last_d        = 1'b0;
                state_d       = ST_WAIT_BLOCK;
            end
            ST_WAIT_BLOCK: begin
                if (input_buffer_ready) begin
                    absorb_enable          = 1'b1;
                    input_buffer_ready_clr = 1'b1;
                    last_d                 = last_block_in_buffer;
                    round_cnt_d            = '0;
                    state_d                = ST_PERMUTE;
                end
            end
            ST_PERMUTE: begin
                busy        = 1'b1;
                round_en    = 1'b1;
                round_index = round_cnt_q;
                round_cnt_d = round_cnt_q + ROUND_STEP_C;
                if (round_cnt_q == ROUND_LAST) begin
                    state_d = last_q ? ST_WAIT_OUTPUT : ST_WAIT_BLOCK;
                end
            end
            ST_WAIT_OUTPUT: begin
                busy = 1'b1;
                if (!output_buffer_ready) begin
                    output_load_enable     = 1'b1;
                    output_buffer_ready_wr = 1'b1;
                    last_output_block      = done_now;
                    squeeze_cnt_d          = squeeze_cnt_q + BLOCK_CNT_W'(1);
                    if (done_now) begin
                        state_d = ST_FLUSH;
                    end else begin
                        round_cnt_d = '0;
                        state_d     = ST_PERMUTE;
                    end
                end
            end
            ST_FLUSH: begin
                state_reset   = 1'b1;
                busy          = 1'b1;
                squeeze_cnt_d = '0;
                last_d        = 1'b0;
                round_cnt_d   = '0;
                state_d       = ST_WAIT_BLOCK;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Reset wins over every datapath strobe; shared flags are left alone.
        if (rst) begin
            state_reset            = 1'b1;
            busy                   = 1'b1;
            absorb_enable          = 1'b0;
            input_buffer_ready_clr = 1'b0;
            round_en               = 1'b0;
            round_index            = '0;
            output_load_enable     = 1'b0;
            output_buffer_ready_wr = 1'b0;
            last_output_block      = 1'b0;
        end
    end

endmodule

// File: tb/tb_permute_fsm.sv
// Bench for permute_fsm: emulates the load/dump stage flags, runs directed
// scenarios then random messages against a transaction-level model.
module tb_permute_fsm;

    localparam int NUM_ROUNDS  = 24;
    localparam int ROUND_W     = 5;
    localparam int BLOCK_CNT_W = 16;
`ifdef PERMUTE_UNROLL2_EN
    localparam int STEP      = 2;
    localparam int EXP_PERM  = 12;
    localparam int EXP_RSUM  = 132;
`else
    localparam int STEP      = 1;
    localparam int EXP_PERM  = 24;
    localparam int EXP_RSUM  = 276;
`endif
    localparam int PERM_CYC = NUM_ROUNDS / STEP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ibr = 1'b0;
    logic obr = 1'b0;
    logic lbib = 1'b0;
    logic ibr_set = 1'b0;
    logic dump_hold = 1'b0;
    logic [BLOCK_CNT_W-1:0] output_blocks = '0;

    logic state_reset, absorb_enable, input_buffer_ready_clr, round_en;
    logic [ROUND_W-1:0] round_index;
    logic output_load_enable, output_buffer_ready_wr, last_output_block, busy;

    permute_fsm #(.NUM_ROUNDS(NUM_ROUNDS), .ROUND_W(ROUND_W), .BLOCK_CNT_W(BLOCK_CNT_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .input_buffer_ready     (ibr),
        .last_block_in_buffer   (lbib),
        .output_buffer_ready    (obr),
        .output_blocks          (output_blocks),
        .state_reset            (state_reset),
        .absorb_enable          (absorb_enable),
        .input_buffer_ready_clr (input_buffer_ready_clr),
        .round_en               (round_en),
        .round_index            (round_index),
        .output_load_enable     (output_load_enable),
        .output_buffer_ready_wr (output_buffer_ready_wr),
        .last_output_block      (last_output_block),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    // Shared handshake flags as the neighbouring stages would keep them.
    always @(posedge clk) begin
        if (ibr_set) ibr <= 1'b1;
        else if (input_buffer_ready_clr) ibr <= 1'b0;
        if (output_buffer_ready_wr) obr <= 1'b1;
        else if (!dump_hold) obr <= 1'b0;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Transaction model: what the controller owes the datapath right now.
    bit m_rst_pend = 0, m_flush = 0, m_wait_out = 0, m_final = 0;
    int m_perm_left = 0, m_outs = 0;

    // Observation logs.
    int absorb_q[$];
    int write_q[$];
    int lastf_q[$];
    int n_round = 0, round_sum = 0, n_sr = 0;

    logic e_sr, e_ab, e_clr, e_ren, e_ole, e_obw, e_lob, e_busy;
    int   e_idx, eff;
    logic [ROUND_W+7:0] exp_v, act_v;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task monitor();
        forever begin
            @(negedge clk);
            cyc++;
            {e_sr, e_ab, e_clr, e_ren, e_ole, e_obw, e_lob, e_busy} = '0;
            e_idx = 0;
            if (rst) begin
                e_sr = 1; e_busy = 1;
                m_rst_pend = 1; m_flush = 0; m_wait_out = 0; m_final = 0;
                m_perm_left = 0; m_outs = 0;
            end else if (m_rst_pend) begin
                e_sr = 1; e_busy = 1; m_rst_pend = 0;
            end else if (m_flush) begin
                e_sr = 1; e_busy = 1; m_flush = 0;
            end else if (m_perm_left > 0) begin
                e_busy = 1; e_ren = 1;
                e_idx = (PERM_CYC - m_perm_left) * STEP;
                m_perm_left--;
                if (m_perm_left == 0 && m_final) m_wait_out = 1;
            end else if (m_wait_out) begin
                e_busy = 1;
                if (!obr) begin
                    e_ole = 1; e_obw = 1;
                    eff = (int'(output_blocks) == 0) ? 1 : int'(output_blocks);
                    e_lob = (m_outs + 1 >= eff);
                    m_outs++;
                    if (e_lob) begin
                        m_wait_out = 0; m_flush = 1; m_outs = 0; m_final = 0;
                    end else begin
                        m_perm_left = PERM_CYC;
                    end
                end
            end else if (ibr) begin
                e_ab = 1; e_clr = 1;
                m_final = lbib;
                m_perm_left = PERM_CYC;
            end
            exp_v = {e_sr, e_ab, e_clr, e_ren, ROUND_W'(e_idx), e_ole, e_obw, e_lob, e_busy};
            act_v = {state_reset, absorb_enable, input_buffer_ready_clr, round_en, round_index,
                     output_load_enable, output_buffer_ready_wr, last_output_block, busy};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL outputs cycle=%0d got=%h expected=%h", cyc, act_v, exp_v);
            end
            if (absorb_enable) absorb_q.push_back(cyc);
            if (round_en) begin n_round++; round_sum += int'(round_index); end
            if (output_buffer_ready_wr) begin
                write_q.push_back(cyc);
                lastf_q.push_back(int'(last_output_block));
            end
            if (state_reset && !rst) n_sr++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_block(input bit last);
        int n = 0;
        while (ibr && n < 300) begin tick(1); n++; end
        if (ibr) check("send_timeout", int'(ibr), 0);
        lbib = last;
        ibr_set = 1'b1;
        tick(1);
        ibr_set = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while ((busy || ibr || obr) && n < 3000) begin
            if (rnd && ($urandom % 4 == 0)) dump_hold = $urandom % 2;
            if (n > 1500) dump_hold = 1'b0;
            tick(1);
            n++;
        end
        dump_hold = 1'b0;
        check("idle_reached", int'(busy | ibr | obr), 0);
    endtask

    int a0, w0, r0, s0, f0, mask, n;

    initial begin
        fork monitor(); join_none

        // Reset held 3 cycles, then one RESET cycle, then idle.
        tick(3);
        check("reset_sr_held", int'(state_reset), 1);
        check("reset_round_idx", int'(round_index), 0);
        rst = 1'b0;
        check("reset_sr_after_release", int'(state_reset), 1);
        check("reset_busy_after_release", int'(busy), 1);
        tick(1);
        check("idle_busy", int'(busy), 0);
        check("idle_sr", int'(state_reset), 0);
        tick(2);

        // Single block, one output block.
        output_blocks = 16'd1;
        a0 = absorb_q.size(); w0 = write_q.size(); r0 = n_round; s0 = round_sum; f0 = n_sr;
        send_block(1'b1);
        wait_idle(1'b0);
        check("t1_absorbs", absorb_q.size() - a0, 1);
        check("t1_writes", write_q.size() - w0, 1);
        check("t1_last", lastf_q[w0], 1);
        check("t1_round_cycles", n_round - r0, EXP_PERM);
        check("t1_round_index_sum", round_sum - s0, EXP_RSUM);
        check("t1_absorb_to_write", write_q[w0] - absorb_q[a0], EXP_PERM + 1);
        check("t1_flush_cycles", n_sr - f0, 1);

        // Three blocks, four output blocks.
        output_blocks = 16'd4;
        a0 = absorb_q.size(); w0 = write_q.size();
        send_block(1'b0);
        send_block(1'b0);
        send_block(1'b1);
        wait_idle(1'b0);
        check("t2_absorbs", absorb_q.size() - a0, 3);
        check("t2_absorb_gap1", absorb_q[a0+1] - absorb_q[a0], EXP_PERM + 1);
        check("t2_absorb_gap2", absorb_q[a0+2] - absorb_q[a0+1], EXP_PERM + 1);
        check("t2_writes", write_q.size() - w0, 4);
        mask = 0;
        for (int i = 0; i < 4; i++) mask |= lastf_q[w0+i] << i;
        check("t2_last_mask", mask, 8);
        check("t2_first_write", write_q[w0] - absorb_q[a0+2], EXP_PERM + 1);
        for (int i = 1; i < 4; i++) check("t2_write_gap", write_q[w0+i] - write_q[w0+i-1], EXP_PERM + 1);

        // Backpressure: output buffer stays occupied well past the next permutation.
        output_blocks = 16'd2;
        w0 = write_q.size();
        dump_hold = 1'b1;
        send_block(1'b1);
        n = 0;
        while (write_q.size() == w0 && n < 200) begin tick(1); n++; end
        check("t3_first_write_seen", write_q.size() - w0, 1);
        tick(EXP_PERM + 12);
        check("t3_held_no_write", write_q.size() - w0, 1);
        dump_hold = 1'b0;
        wait_idle(1'b0);
        check("t3_writes", write_q.size() - w0, 2);
        check("t3_gap_held", int'((write_q[w0+1] - write_q[w0]) >= EXP_PERM + 11), 1);
        check("t3_last_second", lastf_q[w0+1], 1);

        // Zero requested blocks still emits one final block.
        output_blocks = 16'd0;
        w0 = write_q.size();
        send_block(1'b1);
        wait_idle(1'b0);
        check("t4_writes", write_q.size() - w0, 1);
        check("t4_last", lastf_q[w0], 1);

        // Reset in the middle of a permutation.
        output_blocks = 16'd1;
        send_block(1'b1);
        n = 0;
        while (!(round_en && round_index == ROUND_W'(12)) && n < 100) begin tick(1); n++; end
        check("t5_reached_round12", int'(round_index), 12);
        rst = 1'b1;
        #1;
        check("t5_round_en_dropped", int'(round_en), 0);
        check("t5_state_reset", int'(state_reset), 1);
        check("t5_round_index_zero", int'(round_index), 0);
        tick(3);
        rst = 1'b0;
        tick(1);
        check("t5_idle_after", int'(busy), 0);
        wait_idle(1'b0);

        // Random messages.
        for (int m = 0; m < 20; m++) begin
            int nb;
            nb = $urandom_range(1, 3);
            output_blocks = BLOCK_CNT_W'($urandom_range(0, 3));
            dump_hold = $urandom % 2;
            for (int b = 0; b < nb; b++) begin
                tick($urandom_range(0, 30));
                send_block(b == nb - 1);
            end
            wait_idle(1'b1);
            tick($urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
